// File: rtl/pacman_turn_buffer.sv
// Buffers keyboard turn requests and releases them to pacman_move on tile alignment (reversals at once).
// Optional turn statistics ports/counters are built when PACMAN_TURN_STATS_EN is defined.
module pacman_turn_buffer #(
    parameter int TILE_LOG2     = 4,
    parameter int GRID_OFFSET_X = 8,
    parameter int GRID_OFFSET_Y = 9,
    parameter int HOLD_FRAMES   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               playGame,
    input  logic               key_up,
    input  logic               key_down,
    input  logic               key_right,
    input  logic               key_left,
    input  logic signed [10:0] topLeftX,
    input  logic signed [10:0] topLeftY,
    output logic               Y_up_key,
    output logic               Y_down_key,
    output logic               X_right_key,
    output logic               X_left_key,
    output logic               pending_valid,
    output logic [1:0]         pending_dir
`ifdef PACMAN_TURN_STATS_EN
    ,
    output logic [7:0]         turns_issued,
    output logic [7:0]         turns_expired
`endif
);

    localparam logic [1:0] DIR_DOWN  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    localparam logic [TILE_LOG2-1:0] OFF_X     = TILE_LOG2'(GRID_OFFSET_X);
    localparam logic [TILE_LOG2-1:0] OFF_Y     = TILE_LOG2'(GRID_OFFSET_Y);
    localparam logic [7:0]           HOLD_LAST = 8'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {IDLE_ST, PENDING_ST, ISSUE_ST} state_t;

    state_t     state_q, state_d;
    logic [1:0] pending_dir_q, pending_dir_d;
    logic [1:0] cur_dir_q, cur_dir_d;
    logic [1:0] next_dir_q, next_dir_d;
    logic       next_valid_q, next_valid_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] keys_q, keys_d;
    logic       play_q, play_d;
    logic [3:0] out_q, out_d;

    logic [3:0] keys_raw, press_vec;
    logic       press_any;
    logic [1:0] press_dir;
    logic       aligned, play_rise;
    logic [1:0] cur_eff, nd_eff;
    logic       nv_eff;
    logic       issue_evt, expire_evt;

    // key vectors ordered {up, down, right, left}
    assign keys_raw  = {key_up, key_down, key_right, key_left};
    assign press_vec = keys_raw & ~keys_q;
    assign press_any = |press_vec;
    assign aligned   = (topLeftX[TILE_LOG2-1:0] == OFF_X) && (topLeftY[TILE_LOG2-1:0] == OFF_Y);
    assign play_rise = playGame & ~play_q;
    assign cur_eff   = play_rise ? DIR_RIGHT : cur_dir_q;

    always_comb begin
        press_dir = DIR_LEFT;
        if (press_vec[3])      press_dir = DIR_UP;
        else if (press_vec[2]) press_dir = DIR_DOWN;
        else if (press_vec[1]) press_dir = DIR_RIGHT;
    end

    always_comb begin
        state_d       = state_q;
        pending_dir_d = pending_dir_q;
        cur_dir_d     = cur_eff;
        next_dir_d    = next_dir_q;
        next_valid_d  = next_valid_q;
        hold_cnt_d    = hold_cnt_q;
        keys_d        = keys_raw;
        play_d        = playGame;
        out_d         = 4'b0000;
        issue_evt     = 1'b0;
        expire_evt    = 1'b0;
        nv_eff        = next_valid_q | press_any;
        nd_eff        = press_any ? press_dir : next_dir_q;

        if (!playGame) begin
            state_d       = IDLE_ST;
            pending_dir_d = DIR_RIGHT;
            hold_cnt_d    = 8'd0;
            next_valid_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE_ST: begin
                    if (press_any && press_dir != cur_eff) begin
                        pending_dir_d = press_dir;
                        hold_cnt_d    = 8'd0;
                        state_d       = PENDING_ST;
                    end
                end
                PENDING_ST: begin
                    // a fresh press restarts the request; issue beats expiry
                    if (press_any) begin
                        pending_dir_d = press_dir;
                        hold_cnt_d    = 8'd0;
                    end else if (pending_dir_q == ~cur_eff || aligned) begin
                        state_d = ISSUE_ST;
                    end else if (startOfFrame) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_d    = IDLE_ST;
                            hold_cnt_d = 8'd0;
                            expire_evt = 1'b1;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 8'd1;
                        end
                    end
                end
                ISSUE_ST: begin
                    if (press_any) begin
                        next_dir_d   = press_dir;
                        next_valid_d = 1'b1;
                    end
                    if (startOfFrame) begin
                        issue_evt    = 1'b1;
                        cur_dir_d    = pending_dir_q;
                        next_valid_d = 1'b0;
                        // a press caught during the turn becomes the next request
                        if (nv_eff && nd_eff != pending_dir_q) begin
                            pending_dir_d = nd_eff;
                            hold_cnt_d    = 8'd0;
                            state_d       = PENDING_ST;
                        end else begin
                            state_d = IDLE_ST;
                        end
                    end
                end
                default: state_d = IDLE_ST;
            endcase
        end

        if (state_d == ISSUE_ST) out_d[pending_dir_d] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE_ST;
            pending_dir_q <= DIR_RIGHT;
            cur_dir_q     <= DIR_RIGHT;
            next_dir_q    <= DIR_RIGHT;
            next_valid_q  <= 1'b0;
            hold_cnt_q    <= 8'd0;
            keys_q        <= 4'b0000;
            play_q        <= 1'b0;
            out_q         <= 4'b0000;
        end else begin
            state_q       <= state_d;
            pending_dir_q <= pending_dir_d;
            cur_dir_q     <= cur_dir_d;
            next_dir_q    <= next_dir_d;
            next_valid_q  <= next_valid_d;
            hold_cnt_q    <= hold_cnt_d;
            keys_q        <= keys_d;
            play_q        <= play_d;
            out_q         <= out_d;
        end
    end

    assign Y_down_key    = out_q[DIR_DOWN];
    assign X_right_key   = out_q[DIR_RIGHT];
    assign X_left_key    = out_q[DIR_LEFT];
    assign Y_up_key      = out_q[DIR_UP];
    assign pending_valid = (state_q == PENDING_ST) || (state_q == ISSUE_ST);
    assign pending_dir   = pending_dir_q;

    logic unused_pos;
    assign unused_pos = ^{topLeftX[10:TILE_LOG2], topLeftY[10:TILE_LOG2]};

`ifdef PACMAN_TURN_STATS_EN
    logic [7:0] issued_q, issued_d, expired_q, expired_d;

    always_comb begin
        issued_d  = issued_q;
        expired_d = expired_q;
        if (issue_evt && issued_q != 8'hFF)   issued_d  = issued_q + 8'd1;
        if (expire_evt && expired_q != 8'hFF) expired_d = expired_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued_q  <= 8'd0;
            expired_q <= 8'd0;
        end else begin
            issued_q  <= issued_d;
            expired_q <= expired_d;
        end
    end

    assign turns_issued  = issued_q;
    assign turns_expired = expired_q;
`else
    logic unused_stats;
    assign unused_stats = issue_evt ^ expire_evt;
`endif

endmodule

// File: tb/tb_pacman_turn_buffer.sv
// Directed bench for pacman_turn_buffer: alignment wait, reversal, expiry, priority, playGame, chained turn.
module tb_pacman_turn_buffer;

    logic clk, reset, startOfFrame, playGame;
    logic key_up, key_down, key_right, key_left;
    logic signed [10:0] topLeftX, topLeftY;
    logic Y_up_key, Y_down_key, X_right_key, X_left_key, pending_valid;
    logic [1:0] pending_dir;
`ifdef PACMAN_TURN_STATS_EN
    logic [7:0] turns_issued, turns_expired;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pacman_turn_buffer dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .playGame(playGame),
        .key_up(key_up), .key_down(key_down), .key_right(key_right), .key_left(key_left),
        .topLeftX(topLeftX), .topLeftY(topLeftY),
        .Y_up_key(Y_up_key), .Y_down_key(Y_down_key), .X_right_key(X_right_key), .X_left_key(X_left_key),
        .pending_valid(pending_valid), .pending_dir(pending_dir)
`ifdef PACMAN_TURN_STATS_EN
        , .turns_issued(turns_issued), .turns_expired(turns_expired)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    function automatic logic [7:0] outs();
        return {4'b0, Y_up_key, Y_down_key, X_right_key, X_left_key};
    endfunction

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; playGame = 1'b0;
        key_up = 1'b0; key_down = 1'b0; key_right = 1'b0; key_left = 1'b0;
        topLeftX = 11'sd280; topLeftY = 11'sd185;
        tick(); tick();
        chk("reset_outs", outs(), 8'h0);
        chk("reset_pv", 8'(pending_valid), 8'h0);
        chk("reset_pd", 8'(pending_dir), 8'h1);
        reset = 1'b0;

        // 1: aligned, press up
        playGame = 1'b1; tick();
        key_up = 1'b1; tick();
        chk("t1_pv", 8'(pending_valid), 8'h1);
        chk("t1_pd", 8'(pending_dir), 8'h3);
        chk("t1_no_out_yet", outs(), 8'h0);
        tick();
        chk("t1_up", outs(), 8'h8);
        tick();
        startOfFrame = 1'b1; #1;
        chk("t1_up_sof", outs(), 8'h8);
        tick(); startOfFrame = 1'b0;
        chk("t1_after_sof", outs(), 8'h0);
        chk("t1_pv_after", 8'(pending_valid), 8'h0);
        key_up = 1'b0; tick();
        key_up = 1'b1; tick();
        chk("t1_same_dir_ignored", 8'(pending_valid), 8'h0);
        key_up = 1'b0;

        // 2: unaligned, press down, align after 3 frames
        playGame = 1'b0; tick();
        playGame = 1'b1; tick();
        topLeftX = 11'sd281;
        key_down = 1'b1; tick();
        chk("t2_pd", 8'(pending_dir), 8'h0);
        for (int i = 0; i < 3; i++) begin
            sof_pulse(); tick();
            chk("t2_wait_out", outs(), 8'h0);
        end
        chk("t2_wait_pv", 8'(pending_valid), 8'h1);
        topLeftX = 11'sd296; tick();
        chk("t2_down", outs(), 8'h4);
        sof_pulse();
        chk("t2_after_sof", outs(), 8'h0);
        key_down = 1'b0;

        // 3: reversal while unaligned
        playGame = 1'b0; tick();
        playGame = 1'b1; tick();
        topLeftX = 11'sd281;
        key_left = 1'b1; tick();
        chk("t3_pd", 8'(pending_dir), 8'h2);
        chk("t3_no_out_yet", outs(), 8'h0);
        tick();
        chk("t3_left", outs(), 8'h1);
        sof_pulse();
        chk("t3_pv_after", 8'(pending_valid), 8'h0);
        key_left = 1'b0;

        // 4: expiry after HOLD_FRAMES frames (cur is LEFT)
        key_up = 1'b1; tick();
        chk("t4_pv", 8'(pending_valid), 8'h1);
        for (int i = 0; i < 7; i++) begin
            sof_pulse(); tick();
        end
        chk("t4_pv_after7", 8'(pending_valid), 8'h1);
        sof_pulse();
        chk("t4_pv_after8", 8'(pending_valid), 8'h0);
        chk("t4_no_out", outs(), 8'h0);
`ifdef PACMAN_TURN_STATS_EN
        chk("t4_expired", turns_expired, 8'd1);
        chk("t4_issued", turns_issued, 8'd3);
`endif
        key_up = 1'b0; tick();

        // 5: simultaneous press priority, then playGame drop
        key_up = 1'b1; key_left = 1'b1; tick();
        chk("t5_pd_prio", 8'(pending_dir), 8'h3);
        chk("t5_pv", 8'(pending_valid), 8'h1);
        playGame = 1'b0; tick();
        chk("t5_pv_cleared", 8'(pending_valid), 8'h0);
        chk("t5_outs", outs(), 8'h0);
        key_up = 1'b0; key_left = 1'b0; tick();

        // 6: press during issue chains into the next request
        playGame = 1'b1; topLeftX = 11'sd280; tick();
        key_up = 1'b1; tick();
        tick();
        chk("t6_up", outs(), 8'h8);
        key_down = 1'b1; tick();
        chk("t6_up_held", outs(), 8'h8);
        sof_pulse();
        chk("t6_up_low", outs(), 8'h0);
        chk("t6_pv", 8'(pending_valid), 8'h1);
        chk("t6_pd", 8'(pending_dir), 8'h0);
        tick();
        chk("t6_down_reversal", outs(), 8'h4);
`ifdef PACMAN_TURN_STATS_EN
        chk("t6_issued", turns_issued, 8'd4);
`endif
        // asynchronous reset mid-issue
        #2; reset = 1'b1; #1;
        chk("t6_async_reset", outs(), 8'h0);
        chk("t6_async_pv", 8'(pending_valid), 8'h0);
        tick();
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
